// File: rtl/bank_pkg.sv
// Shared types and helpers for the bank queue teller dispatcher.
package bank_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, CALL} state_t;

    localparam int MAX_TELLERS = 3;

    typedef logic [1:0] teller_id_t;

    // Teller i (0-based) is enabled iff i < tcount.
    function automatic logic [MAX_TELLERS-1:0] enable_mask(input logic [1:0] tcount);
        logic [MAX_TELLERS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_TELLERS; i++) begin
            m[i] = (2'(i) < tcount);
        end
        return m;
    endfunction

endpackage

// File: rtl/sync_fall_edge.sv
// Two-flop synchronizer for an idle-high asynchronous input plus a falling-edge
// detector. The edge output is high for exactly one cycle per high-to-low transition.
module sync_fall_edge (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain and one history stage; all idle high out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;

endmodule

// File: rtl/teller_dispatch.sv
// Round-robin dispatcher that calls waiting customers to ready tellers and strobes
// the queue dequeue on customer exit or call timeout.
module teller_dispatch
    import bank_pkg::*;
#(
    parameter int N_TELLERS    = 3,
    parameter int CNT_W        = 3,
    parameter int CALL_TIMEOUT = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_TELLERS-1:0] teller_rdy_n,
    input  logic [1:0]           tcount,
    input  logic [CNT_W-1:0]     pcount,
    input  logic                 empty_flag,
    input  logic                 phc_exit_n,
    output logic                 deq_pulse,
    output logic                 call_valid,
    output logic [1:0]           call_id,
    output logic [N_TELLERS-1:0] pending,
    output logic                 noshow_pulse
);

    localparam int TIMER_W = (CALL_TIMEOUT > 1) ? $clog2(CALL_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CALL_TIMEOUT - 1);

    state_t               state;
    teller_id_t           gnt;
    teller_id_t           rr_ptr;
    logic [TIMER_W-1:0]   timer;

    logic [N_TELLERS-1:0] teller_evt;
    logic                 exit_evt;
    logic [MAX_TELLERS-1:0] mask_full;
    logic [N_TELLERS-1:0] en_mask;
    logic [N_TELLERS-1:0] eligible;
    logic [N_TELLERS-1:0] gnt_onehot;
    logic [N_TELLERS-1:0] keep_mask;
    logic [N_TELLERS-1:0] pending_upd;
    logic                 q_avail;
    logic                 sel_found;
    teller_id_t           sel_idx;
    logic [2:0]           cand;
    logic [2:0]           rr_sum;
    teller_id_t           rr_next;

    for (genvar i = 0; i < N_TELLERS; i++) begin : g_teller_sync
        sync_fall_edge u_sync (
            .clock (clock),
            .reset (reset),
            .din   (teller_rdy_n[i]),
            .fall  (teller_evt[i])
        );
    end

    sync_fall_edge u_exit_sync (
        .clock (clock),
        .reset (reset),
        .din   (phc_exit_n),
        .fall  (exit_evt)
    );

    assign mask_full = enable_mask(tcount);
    assign en_mask   = mask_full[N_TELLERS-1:0];
    assign eligible  = pending & en_mask;

    // pcount is only a consistency check: a queue claiming non-empty with zero
    // occupancy is treated as empty.
    assign q_avail = ~empty_flag & (|pcount);

    // Pending update: latch enabled presses, drop disabled tellers except the one on call.
    always_comb begin
        for (int i = 0; i < N_TELLERS; i++) begin
            gnt_onehot[i] = (gnt == 2'(i));
        end
        keep_mask   = en_mask | ((state == CALL) ? gnt_onehot : '0);
        pending_upd = (pending | (teller_evt & en_mask)) & keep_mask;
    end

    // Round-robin pick: first eligible teller at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_TELLERS; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'(N_TELLERS)) begin
                cand = cand - 3'(N_TELLERS);
            end
            if (!sel_found && eligible[cand[1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[1:0];
            end
        end
    end

    // Pointer to the teller after the one just served.
    always_comb begin
        rr_sum = {1'b0, gnt} + 3'd1;
        if (rr_sum >= 3'(N_TELLERS)) begin
            rr_sum = rr_sum - 3'(N_TELLERS);
        end
        rr_next = rr_sum[1:0];
    end

    // Dispatch FSM with registered call and pulse outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            gnt          <= '0;
            rr_ptr       <= '0;
            timer        <= '0;
            pending      <= '0;
            deq_pulse    <= 1'b0;
            noshow_pulse <= 1'b0;
            call_valid   <= 1'b0;
            call_id      <= '0;
        end else begin
            deq_pulse    <= 1'b0;
            noshow_pulse <= 1'b0;
            pending      <= pending_upd;
            unique case (state)
                IDLE: begin
                    // Exit events here belong to nobody and are dropped.
                    if ((|eligible) && q_avail) begin
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (sel_found) begin
                        gnt        <= sel_idx;
                        timer      <= '0;
                        call_valid <= 1'b1;
                        call_id    <= sel_idx + 2'd1;
                        state      <= CALL;
                    end else begin
                        // Eligibility vanished (tcount dropped) between IDLE and GRANT.
                        state <= IDLE;
                    end
                end
                CALL: begin
                    if (exit_evt) begin
                        deq_pulse  <= 1'b1;
                        pending    <= pending_upd & ~gnt_onehot;
                        rr_ptr     <= rr_next;
                        call_valid <= 1'b0;
                        call_id    <= '0;
                        state      <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        // No-show: drop the customer but keep the teller's request.
                        deq_pulse    <= 1'b1;
                        noshow_pulse <= 1'b1;
                        call_valid   <= 1'b0;
                        call_id      <= '0;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_teller_dispatch.sv
// Self-checking bench for teller_dispatch: directed scenarios with literal
// expectations plus a long randomized run against a behavioural model.
module tb_teller_dispatch;

    localparam int NT = 3;
    localparam int CW = 3;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NT-1:0] teller_rdy_n = '1;
    logic [1:0]    tcount = 2'd3;
    logic [CW-1:0] pcount = 3'd3;
    logic          empty_flag = 1'b0;
    logic          phc_exit_n = 1'b1;
    logic          deq_pulse;
    logic          call_valid;
    logic [1:0]    call_id;
    logic [NT-1:0] pending;
    logic          noshow_pulse;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    always #5 clock = ~clock;

    teller_dispatch #(
        .N_TELLERS    (NT),
        .CNT_W        (CW),
        .CALL_TIMEOUT (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .teller_rdy_n (teller_rdy_n),
        .tcount       (tcount),
        .pcount       (pcount),
        .empty_flag   (empty_flag),
        .phc_exit_n   (phc_exit_n),
        .deq_pulse    (deq_pulse),
        .call_valid   (call_valid),
        .call_id      (call_id),
        .pending      (pending),
        .noshow_pulse (noshow_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pin histories: value sampled 1, 2 and 3 edges ago (idle high).
    logic [NT-1:0] h1, h2, h3;
    logic          x1, x2, x3;
    logic [NT-1:0] m_pending;
    logic          m_open;      // a customer is on call
    logic          m_picking;   // a teller will be chosen at the next edge
    int            m_gnt, m_age, m_rr;
    logic          m_cv, m_deq, m_ns;
    logic [1:0]    m_id;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            h1 = '1; h2 = '1; h3 = '1;
            x1 = 1'b1; x2 = 1'b1; x3 = 1'b1;
            m_pending = '0; m_open = 1'b0; m_picking = 1'b0;
            m_gnt = 0; m_age = 0; m_rr = 0;
            m_cv = 1'b0; m_deq = 1'b0; m_ns = 1'b0; m_id = 2'd0;
        end else begin : step
            logic [NT-1:0] evt, mask, old_p, np;
            logic xevt;
            int c;
            // A press is seen once the low level has crossed the synchronizer.
            evt  = h3 & ~h2;
            xevt = x3 & ~x2;
            h3 = h2; h2 = h1; h1 = teller_rdy_n;
            x3 = x2; x2 = x1; x1 = phc_exit_n;
            for (int i = 0; i < NT; i++) mask[i] = (i < int'(tcount));
            old_p = m_pending;
            np = old_p | (evt & mask);
            for (int i = 0; i < NT; i++) begin
                if (!mask[i] && !(m_open && i == m_gnt)) np[i] = 1'b0;
            end
            m_deq = 1'b0;
            m_ns  = 1'b0;
            if (m_open) begin
                if (xevt) begin
                    m_deq = 1'b1;
                    np[m_gnt] = 1'b0;
                    m_rr = (m_gnt + 1) % NT;
                    m_open = 1'b0;
                end else if (m_age == TO - 1) begin
                    m_deq = 1'b1;
                    m_ns = 1'b1;
                    m_open = 1'b0;
                end else begin
                    m_age++;
                end
            end else if (m_picking) begin
                m_picking = 1'b0;
                for (int k = 0; k < NT; k++) begin
                    c = (m_rr + k) % NT;
                    if (!m_open && old_p[c] && mask[c]) begin
                        m_open = 1'b1;
                        m_gnt = c;
                        m_age = 0;
                    end
                end
            end else if ((old_p & mask) != 0 && !empty_flag && pcount != 0) begin
                m_picking = 1'b1;
            end
            m_pending = np;
            m_cv = m_open;
            m_id = m_open ? 2'(m_gnt + 1) : 2'd0;
        end
    end

    // Compare the DUT to the model every cycle, mid-period.
    always @(negedge clock) begin
        if (chk_on) begin
            check("m_call_valid", call_valid, m_cv);
            check("m_call_id", call_id, m_id);
            check("m_pending", pending, m_pending);
            check("m_deq_pulse", deq_pulse, m_deq);
            check("m_noshow_pulse", noshow_pulse, m_ns);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic wait_call(input int exp_id, output int waited);
        waited = 0;
        while (call_valid !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check("call_seen_in_time", waited < 40, 1);
        check("call_id_directed", call_id, exp_id);
    endtask

    // Drops the exit beam and returns on the cycle deq_pulse shows.
    task automatic exit_pulse(output int at);
        at = 0;
        phc_exit_n = 1'b0;
        while (deq_pulse !== 1'b1 && at < 10) begin
            tick();
            at++;
        end
        phc_exit_n = 1'b1;
        check("exit_deq_latency", at, 3);
    endtask

    int w, n;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk_on = 1'b1;

        // Single press: latency and exit.
        apply_reset();
        teller_rdy_n[1] = 1'b0;
        ticks(2);
        check("pend_before_edge3", pending, 3'b000);
        tick();
        check("pend_edge3", pending, 3'b010);
        tick();
        check("cv_edge4", call_valid, 0);
        tick();
        check("cv_edge5", call_valid, 1);
        check("id_edge5", call_id, 2);
        teller_rdy_n = '1;
        exit_pulse(w);
        check("exit_cv_clear", call_valid, 0);
        check("exit_pend_clear", pending, 3'b000);
        check("exit_no_noshow", noshow_pulse, 0);
        tick();
        check("deq_one_cycle", deq_pulse, 0);

        // Round robin between tellers 1 and 3.
        apply_reset();
        teller_rdy_n = 3'b010;
        wait_call(1, w);
        check("pair_latency", w, 5);
        teller_rdy_n = '1;
        exit_pulse(w);
        wait_call(3, w);
        teller_rdy_n[0] = 1'b0;
        exit_pulse(w);
        teller_rdy_n = '1;
        wait_call(1, w);
        exit_pulse(w);

        // Disabled teller and empty queue gating.
        apply_reset();
        tcount = 2'd2;
        teller_rdy_n[2] = 1'b0;
        ticks(6);
        check("disabled_pend", pending, 3'b000);
        check("disabled_no_call", call_valid, 0);
        teller_rdy_n = '1;
        empty_flag = 1'b1;
        pcount = 3'd0;
        teller_rdy_n[0] = 1'b0;
        ticks(4);
        check("empty_pend", pending, 3'b001);
        ticks(5);
        check("empty_no_call", call_valid, 0);
        teller_rdy_n = '1;
        empty_flag = 1'b0;
        pcount = 3'd2;
        wait_call(1, w);
        exit_pulse(w);

        // Timeout, re-call, then exit coinciding with the timeout cycle.
        apply_reset();
        tcount = 2'd3;
        teller_rdy_n[2] = 1'b0;
        wait_call(3, w);
        teller_rdy_n = '1;
        n = 0;
        while (noshow_pulse !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_deq", deq_pulse, 1);
        check("timeout_pend_kept", pending, 3'b100);
        check("timeout_cv_clear", call_valid, 0);
        wait_call(3, w);
        check("recall_gap", w, 2);
        ticks(5);
        phc_exit_n = 1'b0;
        ticks(3);
        check("coinc_deq", deq_pulse, 1);
        check("coinc_noshow", noshow_pulse, 0);
        check("coinc_pend_clear", pending, 3'b000);
        phc_exit_n = 1'b1;
        ticks(3);

        // Asynchronous reset in the middle of a call.
        apply_reset();
        teller_rdy_n[1] = 1'b0;
        wait_call(2, w);
        teller_rdy_n = '1;
        ticks(2);
        reset = 1'b1;
        #1;
        check("rst_cv", call_valid, 0);
        check("rst_id", call_id, 0);
        check("rst_pend", pending, 3'b000);
        check("rst_deq", deq_pulse, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_hold_deq", deq_pulse, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_deq", deq_pulse, 0);
            check("post_rst_cv", call_valid, 0);
        end

        // Randomized traffic against the model.
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NT; i++) begin
                if (teller_rdy_n[i] == 1'b0) begin
                    if ($urandom_range(3, 0) == 0) teller_rdy_n[i] = 1'b1;
                end else if ($urandom_range(19, 0) == 0) begin
                    teller_rdy_n[i] = 1'b0;
                end
            end
            if (phc_exit_n == 1'b0) begin
                if ($urandom_range(1, 0) == 0) phc_exit_n = 1'b1;
            end else if ($urandom_range(11, 0) == 0) begin
                phc_exit_n = 1'b0;
            end
            if ($urandom_range(99, 0) == 0) tcount = 2'($urandom_range(3, 0));
            if ($urandom_range(29, 0) == 0) empty_flag = ~empty_flag;
            pcount = empty_flag ? 3'd0 : 3'($urandom_range(7, 1));
            tick();
        end
        teller_rdy_n = '1;
        phc_exit_n = 1'b1;
        ticks(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
